// File: rtl/fir_bank_engine_if.sv
// Sample/result handshake and coefficient write port of the multi-bank FIR engine.
// master drives requests (the sample source), slave is the engine.
interface fir_bank_engine_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int SEL_W  = 2,
  parameter int IDX_W  = 5
);
  logic                     start;
  logic signed [DATA_W-1:0] sample;
  logic        [SEL_W-1:0]  filt_sel;
  logic                     hist_clr;
  logic                     coef_we;
  logic        [SEL_W-1:0]  coef_bank;
  logic        [IDX_W-1:0]  coef_idx;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_err;
  logic                     busy;
  logic                     done;
  logic signed [DATA_W-1:0] result;
  logic                     sat;

  modport master (
    output start, sample, filt_sel, hist_clr, coef_we, coef_bank, coef_idx, coef_wdata,
    input  coef_err, busy, done, result, sat
  );

  modport slave (
    input  start, sample, filt_sel, hist_clr, coef_we, coef_bank, coef_idx, coef_wdata,
    output coef_err, busy, done, result, sat
  );
endinterface

// File: rtl/fir_bank_engine.sv
// Time-multiplexed FIR: one MAC per tap over a shared history ring, NFILT coefficient
// banks, bypass select, round-half-up and saturate on the way out.
module fir_bank_engine #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 16,
  parameter int TAPS      = 23,
  parameter int NFILT     = 3,
  parameter int SEL_W     = 2,
  parameter int IDX_W     = 5
) (
  input logic clk,
  input logic rst,
  fir_bank_engine_if.slave bus
);

  localparam int CNT_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + CNT_W;

  localparam logic [IDX_W-1:0] LAST   = IDX_W'(TAPS - 1);
  localparam logic [SEL_W:0]   NF_X   = (SEL_W + 1)'(NFILT);
  localparam logic [IDX_W:0]   TAPS_X = (IDX_W + 1)'(TAPS);

  localparam logic signed [ACC_W-1:0] RND  =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_MAC, S_FINAL} state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     sat_q, sat_d;
  logic                     err_q, err_d;
  logic                     byp_q, byp_d;
  logic signed [DATA_W-1:0] result_q, result_d;
  logic signed [DATA_W-1:0] samp_q, samp_d;
  logic        [SEL_W-1:0]  sel_q, sel_d;
  logic        [IDX_W-1:0]  wp_q, wp_d;
  logic        [IDX_W-1:0]  rd_q, rd_d;
  logic        [IDX_W-1:0]  k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic signed [COEF_W-1:0] coef_q [NFILT][TAPS];

  logic                     hist_we, hist_clr_en, cw_ok;
  logic signed [DATA_W-1:0] hist_wdata, hist_rd;
  logic signed [COEF_W-1:0] coef_rd;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  rsum, rsh;
  logic        [IDX_W-1:0]  wp_nxt;

  assign hist_rd = hist_q[rd_q];
  assign coef_rd = coef_q[sel_q][k_q];
  // Operands widened first so the multiply is a full-precision signed product.
  assign prod    = PROD_W'(hist_rd) * PROD_W'(coef_rd);
  assign rsum    = acc_q + RND;
  assign rsh     = rsum >>> COEF_FRAC;
  assign wp_nxt  = (wp_q == LAST) ? '0 : wp_q + 1'b1;

  assign cw_ok = bus.coef_we && !busy_q &&
                 ({1'b0, bus.coef_bank} < NF_X) && ({1'b0, bus.coef_idx} < TAPS_X);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sat_d       = sat_q;
    result_d    = result_q;
    samp_d      = samp_q;
    sel_d       = sel_q;
    byp_d       = byp_q;
    wp_d        = wp_q;
    rd_d        = rd_q;
    k_d         = k_q;
    acc_d       = acc_q;
    hist_we     = 1'b0;
    hist_wdata  = samp_q;
    hist_clr_en = 1'b0;
    err_d       = bus.coef_we && !cw_ok;
    case (state_q)
      S_IDLE: begin
        if (bus.hist_clr) begin
          hist_clr_en = 1'b1;
          wp_d        = '0;
        end else if (bus.start) begin
          busy_d = 1'b1;
          samp_d = bus.sample;
          sel_d  = bus.filt_sel;
          if ({1'b0, bus.filt_sel} < NF_X) begin
            byp_d   = 1'b0;
            state_d = S_WRITE;
          end else begin
            // Bypass still feeds the history so later filtered runs see this sample.
            byp_d      = 1'b1;
            hist_we    = 1'b1;
            hist_wdata = bus.sample;
            wp_d       = wp_nxt;
            state_d    = S_FINAL;
          end
        end
      end
      S_WRITE: begin
        hist_we = 1'b1;
        wp_d    = wp_nxt;
        rd_d    = wp_q;
        acc_d   = '0;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        k_d   = k_q + 1'b1;
        rd_d  = (rd_q == '0) ? LAST : rd_q - 1'b1;
        if (k_q == LAST) state_d = S_FINAL;
      end
      S_FINAL: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (byp_q) begin
          result_d = samp_q;
          sat_d    = 1'b0;
        end else if (rsh > MAXV) begin
          result_d = MAXV[DATA_W-1:0];
          sat_d    = 1'b1;
        end else if (rsh < MINV) begin
          result_d = MINV[DATA_W-1:0];
          sat_d    = 1'b1;
        end else begin
          result_d = rsh[DATA_W-1:0];
          sat_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
      byp_q    <= 1'b0;
      result_q <= '0;
      samp_q   <= '0;
      sel_q    <= '0;
      wp_q     <= '0;
      rd_q     <= '0;
      k_q      <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
      byp_q    <= byp_d;
      result_q <= result_d;
      samp_q   <= samp_d;
      sel_q    <= sel_d;
      wp_q     <= wp_d;
      rd_q     <= rd_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
    end else if (hist_clr_en) begin
      for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
    end else if (hist_we) begin
      hist_q[wp_q] <= hist_wdata;
    end
  end

  // Coefficient RAM has no reset; contents are meaningful only once written.
  always_ff @(posedge clk) begin
    if (cw_ok) coef_q[bus.coef_bank][bus.coef_idx] <= bus.coef_wdata;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.sat      = sat_q;
  assign bus.coef_err = err_q;

endmodule

// File: doc/fir_bank_engine.md
Name: fir_bank_engine

Overview:
Parametrised multi-bank FIR engine for the oscilloscope filter path. It replaces the fixed three-filter wrapper with a single time-multiplexed MAC datapath shared by NFILT coefficient banks. The block has an internal sample history ring buffer, a runtime-writable coefficient memory, a bypass mode, and round and saturate output stages. It sits between the XADC sample stream and the display/capture path.

Parameters:
DATA_W, 16, sample/result width, signed two's complement
COEF_W, 32, coefficient width, signed
COEF_FRAC, 16, fractional bits of coefficients (Q(COEF_W-COEF_FRAC).COEF_FRAC)
TAPS, 23, filter length and history depth (2..64)
NFILT, 3, number of coefficient banks
SEL_W, 2, filter select width; must satisfy 2^SEL_W > NFILT
IDX_W, 5, tap index width; must satisfy 2^IDX_W >= TAPS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request to process one sample; level-sampled on the rising edge
sample  in  DATA_W  new input sample, captured on the accepting edge
filt_sel  in  SEL_W  bank select, captured on the accepting edge; any value >= NFILT selects bypass
hist_clr  in  1  synchronous clear of the sample history; honoured only in IDLE
coef_we  in  1  coefficient write strobe
coef_bank  in  SEL_W  bank to write
coef_idx  in  IDX_W  tap index to write (0 = newest sample)
coef_wdata  in  COEF_W  coefficient value
coef_err  out  1  one-cycle pulse when a coefficient write is rejected
busy  out  1  high from the accepting edge until done
done  out  1  one-cycle pulse; result is valid from this cycle on
result  out  DATA_W  last filter output; held until the next done
sat  out  1  high when the last result was saturated; updated with done

Behaviour:
- Reset: async clears state to IDLE, busy=0, done=0, result=0, sat=0, coef_err=0, all history entries=0, write pointer=0. Coefficient memory is not reset; its contents are undefined until written.
- Reset mid-operation aborts the computation immediately. No done is produced.
- States: IDLE, WRITE, MAC, FINAL.
- IDLE: on an edge with start=1, latch sample and filt_sel, and set busy=1. If filt_sel < NFILT go to WRITE; otherwise take the bypass path below.
- WRITE (1 cycle): store the sample at the write pointer, advance the pointer modulo TAPS (TAPS-1 wraps to 0), clear the accumulator and tap counter k.
- MAC (TAPS cycles, k=0..TAPS-1): acc += hist[newest-k mod TAPS] * coef[bank][k]. Products are full precision DATA_W+COEF_W bits. acc width is DATA_W+COEF_W+clog2(TAPS) bits, so the accumulator cannot overflow.
- FINAL (1 cycle):
  - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up, arithmetic shift).
  - If r is outside the signed DATA_W range, result saturates to max/min and sat=1; otherwise result = r and sat=0.
  - done=1 and busy=0 for one cycle; next state IDLE.
- Latency: for a start accepted at edge E, result/done/sat update at edge E+TAPS+2. The next start is accepted at that same edge or later; back-to-back throughput is one sample every TAPS+2 cycles.
- Bypass: the sample is still written to history and the pointer advances. result=sample, sat=0, done pulses at E+1, busy high for E..E+1 only.
- start while busy is ignored; the sample is not queued. start held high re-triggers on the first IDLE edge.
- hist_clr in IDLE zeroes the history and pointer in 1 cycle. If start and hist_clr are both high in IDLE, the clear wins and start is ignored that cycle. hist_clr while busy is ignored.
- Coefficient write, accepted: coef_we=1 with busy=0 and coef_bank<NFILT and coef_idx<TAPS writes on that edge. A write accepted in the same edge as start takes effect before MAC.
- Coefficient write, rejected: coef_we=1 while busy, or with an out-of-range bank/idx, drops the write and pulses coef_err on the next cycle.
- result and sat hold their value between done pulses. The first result after reset reflects zero history apart from the new sample.

Test Plan:
- Impulse: load bank0 coef[k]=(k+1)<<16, send sample 100 then 22 zeros -> results 100,200,...,2300 in order; each done exactly 25 cycles after its start; the 24th result is 0 (history wrap).
- Bypass: filt_sel=3, sample=-1234 -> done 1 cycle after start, result=-1234, sat=0. A following bank0 run with coef0=1.0 only returns -1234 for the history entry one step back (coef1=1.0).
- Saturation: bank1 all coefs=4.0 (0x40000), sample 32767 -> result 32767, sat=1. Sample -32768 -> result -32768, sat=1.
- Rounding: coef0=0x00008000 (0.5), sample 3 -> result 2; sample -3 -> result -1.
- Busy rules: start at E and again at E+5 -> only one done at E+25. A coef write during busy is dropped and coef_err pulses once; hist_clr during busy has no effect.
- Reset mid-MAC: assert rst at E+10 -> busy=0, done never pulses, result=0. A following start with sample 5 and coef0=1.0 yields 5 (history was cleared).
